// File: rtl/line_stream_tx_pkg.sv
// Shared definitions for the line stream transmitter: command bytes,
// pixel address split, FSM state encoding and row digit helpers.
package line_stream_tx_pkg;

    localparam logic [7:0] CMD_LINE   = 8'h4C;
    localparam logic [7:0] ASCII_ZERO = 8'h30;

    localparam int ROW_BITS  = 5;
    localparam int COL_BITS  = 6;
    localparam int ADDR_BITS = ROW_BITS + COL_BITS;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_TENS,
        ST_ONES,
        ST_FETCH,
        ST_PIX_HI,
        ST_PIX_LO,
        ST_GAP
    } state_e;

    // Decimal split of a 0..31 row using compares only.
    function automatic logic [1:0] row_tens(input logic [ROW_BITS-1:0] row);
        if (row >= 5'd30) return 2'd3;
        if (row >= 5'd20) return 2'd2;
        if (row >= 5'd10) return 2'd1;
        return 2'd0;
    endfunction

    function automatic logic [3:0] row_ones(input logic [ROW_BITS-1:0] row);
        logic [ROW_BITS-1:0] r;
        r = row;
        if (row >= 5'd30)      r = row - 5'd30;
        else if (row >= 5'd20) r = row - 5'd20;
        else if (row >= 5'd10) r = row - 5'd10;
        return r[3:0];
    endfunction

endpackage

// File: rtl/line_stream_tx_uart_tx_byte.sv
// uart_tx_byte: 8N1 serialiser, LSB first, one byte per valid/ready handshake.
// Ports: clk_in, reset (async high), byte_valid/byte_data in, byte_ready out
// (high only while idle), tx_out (registered, idle high).
module uart_tx_byte #(
    parameter int UART_TICKS_PER_BIT = 20,
    parameter int UART_TICKS_WIDTH   = 5
) (
    input  logic       clk_in,
    input  logic       reset,
    input  logic       byte_valid,
    input  logic [7:0] byte_data,
    output logic       byte_ready,
    output logic       tx_out
);

    localparam logic [3:0] STOP_BIT = 4'd9;
    localparam logic [UART_TICKS_WIDTH-1:0] TICK_LAST =
        UART_TICKS_WIDTH'(UART_TICKS_PER_BIT - 1);
    // The stop bit leaves the active state one tick early: the idle cycle
    // that follows is the stop bit's last cycle, so a waiting byte starts
    // exactly one bit period later with no extra idle time.
    localparam logic [UART_TICKS_WIDTH-1:0] TICK_STOP =
        UART_TICKS_WIDTH'(UART_TICKS_PER_BIT - 2);

    logic                        active_q, active_d;
    logic                        tx_q, tx_d;
    logic [8:0]                  shift_q, shift_d;
    logic [3:0]                  bit_q, bit_d;
    logic [UART_TICKS_WIDTH-1:0] tick_q, tick_d;

    assign byte_ready = !active_q;
    assign tx_out     = tx_q;

    always_comb begin
        active_d = active_q;
        tx_d     = tx_q;
        shift_d  = shift_q;
        bit_d    = bit_q;
        tick_d   = tick_q;
        if (!active_q) begin
            if (byte_valid) begin
                active_d = 1'b1;
                tx_d     = 1'b0;
                shift_d  = {1'b1, byte_data};
                bit_d    = '0;
                tick_d   = '0;
            end
        end else if (bit_q == STOP_BIT && tick_q == TICK_STOP) begin
            active_d = 1'b0;
        end else if (tick_q == TICK_LAST) begin
            tick_d  = '0;
            bit_d   = bit_q + 4'd1;
            tx_d    = shift_q[0];
            shift_d = {1'b1, shift_q[8:1]};
        end else begin
            tick_d = tick_q + UART_TICKS_WIDTH'(1);
        end
    end

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            active_q <= 1'b0;
            tx_q     <= 1'b1;
            shift_q  <= '1;
            bit_q    <= '0;
            tick_q   <= '0;
        end else begin
            active_q <= active_d;
            tx_q     <= tx_d;
            shift_q  <= shift_d;
            bit_q    <= bit_d;
            tick_q   <= tick_d;
        end
    end

endmodule

// File: rtl/line_stream_tx.sv
// line_stream_tx: reads rows of RGB565 pixels and sends each as an
// "L<tens><ones><pixels>" line over 8N1 UART, one row or a full frame.
// Ports: clk_in, reset (async high), start/frame_mode/start_row request,
// pixel_rd/pixel_addr/pixel_data framebuffer port, tx_out serial line,
// busy while a transfer runs, done one-cycle completion pulse.
module line_stream_tx
    import line_stream_tx_pkg::*;
#(
    parameter int UART_TICKS_PER_BIT = 20,
    parameter int UART_TICKS_WIDTH   = 5,
    parameter int COLUMNS            = 64,
    parameter int ROWS               = 32,
    parameter int LINE_GAP_TICKS     = 40
) (
    input  logic                 clk_in,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 frame_mode,
    input  logic [ROW_BITS-1:0]  start_row,
    output logic                 pixel_rd,
    output logic [ADDR_BITS-1:0] pixel_addr,
    input  logic [15:0]          pixel_data,
    output logic                 tx_out,
    output logic                 busy,
    output logic                 done
);

    localparam int GAP_W = $clog2(LINE_GAP_TICKS + 1) + 1;
    localparam logic [COL_BITS-1:0] LAST_COL = COL_BITS'(COLUMNS - 1);
    localparam logic [ROW_BITS-1:0] LAST_ROW = ROW_BITS'(ROWS - 1);
    localparam logic [GAP_W-1:0]    GAP_END  = GAP_W'(LINE_GAP_TICKS);
    // Continuing a frame leaves one cycle early: the next L is accepted a
    // cycle later, so its start bit lands exactly LINE_GAP_TICKS after the
    // previous stop bit, matching where done would have risen.
    localparam logic [GAP_W-1:0]    GAP_NEXT = GAP_W'(LINE_GAP_TICKS - 1);

    state_e              state_q, state_d;
    logic [ROW_BITS-1:0] row_q, row_d;
    logic [COL_BITS-1:0] col_q, col_d;
    logic                frame_q, frame_d;
    logic                wait_q, wait_d;
    logic [15:0]         pix_q, pix_d;
    logic [GAP_W-1:0]    gap_q, gap_d;
    logic                done_q, done_d;

    logic                byte_valid;
    logic [7:0]          byte_data;
    logic                byte_ready;

    assign pixel_addr = {row_q, col_q};
    assign busy       = (state_q != ST_IDLE);
    assign done       = done_q;

    always_comb begin
        state_d    = state_q;
        row_d      = row_q;
        col_d      = col_q;
        frame_d    = frame_q;
        wait_d     = 1'b0;
        pix_d      = pix_q;
        gap_d      = gap_q;
        done_d     = 1'b0;
        byte_valid = 1'b0;
        byte_data  = CMD_LINE;
        pixel_rd   = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    frame_d = frame_mode;
                    row_d   = frame_mode ? '0 : start_row;
                    col_d   = '0;
                    state_d = ST_CMD;
                end
            end
            ST_CMD: begin
                byte_valid = 1'b1;
                byte_data  = CMD_LINE;
                if (byte_ready) state_d = ST_TENS;
            end
            ST_TENS: begin
                byte_valid = 1'b1;
                byte_data  = ASCII_ZERO + {6'd0, row_tens(row_q)};
                if (byte_ready) state_d = ST_ONES;
            end
            ST_ONES: begin
                byte_valid = 1'b1;
                byte_data  = ASCII_ZERO + {4'd0, row_ones(row_q)};
                if (byte_ready) state_d = ST_FETCH;
            end
            ST_FETCH: begin
                // First cycle strobes the read, second captures the data.
                if (!wait_q) begin
                    pixel_rd = 1'b1;
                    wait_d   = 1'b1;
                end else begin
                    pix_d   = pixel_data;
                    state_d = ST_PIX_HI;
                end
            end
            ST_PIX_HI: begin
                byte_valid = 1'b1;
                byte_data  = pix_q[15:8];
                if (byte_ready) state_d = ST_PIX_LO;
            end
            ST_PIX_LO: begin
                byte_valid = 1'b1;
                byte_data  = pix_q[7:0];
                if (byte_ready) begin
                    if (col_q == LAST_COL) begin
                        gap_d   = '0;
                        state_d = ST_GAP;
                    end else begin
                        col_d   = col_q + COL_BITS'(1);
                        state_d = ST_FETCH;
                    end
                end
            end
            ST_GAP: begin
                // Counting starts once the serialiser has gone idle.
                if (byte_ready) begin
                    if (frame_q && row_q != LAST_ROW) begin
                        if (gap_q == GAP_NEXT) begin
                            row_d   = row_q + ROW_BITS'(1);
                            col_d   = '0;
                            state_d = ST_CMD;
                        end else begin
                            gap_d = gap_q + GAP_W'(1);
                        end
                    end else if (gap_q == GAP_END) begin
                        done_d  = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        gap_d = gap_q + GAP_W'(1);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            row_q   <= '0;
            col_q   <= '0;
            frame_q <= 1'b0;
            wait_q  <= 1'b0;
            pix_q   <= '0;
            gap_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            col_q   <= col_d;
            frame_q <= frame_d;
            wait_q  <= wait_d;
            pix_q   <= pix_d;
            gap_q   <= gap_d;
            done_q  <= done_d;
        end
    end

    uart_tx_byte #(
        .UART_TICKS_PER_BIT (UART_TICKS_PER_BIT),
        .UART_TICKS_WIDTH   (UART_TICKS_WIDTH)
    ) u_ser (
        .clk_in     (clk_in),
        .reset      (reset),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .byte_ready (byte_ready),
        .tx_out     (tx_out)
    );

endmodule
